sram_axi_bridge: RTL and testbench

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

---
 rtl/cpu_axi_pkg.sv | 19 +
 rtl/sram_axi_arb.sv | 14 +
 rtl/sram_axi_bridge.sv | 172 +++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_axi_pkg.sv
// rtl/cpu_axi_pkg.sv - shared types and constants for the SRAM-to-AXI bridge
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AWW,
    ST_B,
    ST_DONE
  } bridge_state_e;

  localparam logic [3:0] ARID_INST = 4'd0;
  localparam logic [3:0] ARID_DATA = 4'd1;

  // every AXI transfer is a single 4-byte beat
  localparam int XFER_BYTES = 4;

endpackage

// File: rtl/sram_axi_arb.sv
// rtl/sram_axi_arb.sv - fixed-priority grant between data and instruction ports
module sram_axi_arb (
  input  logic enable,
  input  logic inst_req,
  input  logic data_req,
  output logic inst_gnt,
  output logic data_gnt
);

  // data port always wins; nothing is granted unless the bridge is idle
  assign data_gnt = enable & data_req;
  assign inst_gnt = enable & inst_req & ~data_req;

endmodule

// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - single-outstanding SRAM-style to AXI bridge
module sram_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [XFER_BYTES-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  output logic [DATA_W-1:0]     wdata,
  output logic [XFER_BYTES-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  awready,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  bridge_state_e state, state_nxt;

  logic                  idle;
  logic                  inst_gnt, data_gnt;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [XFER_BYTES-1:0] wstrb_q;
  logic                  wr_q;
  logic                  port_data_q;
  logic                  aw_done, w_done;
  logic                  aw_all, w_all;
  logic [DATA_W-1:0]     inst_rdata_q, data_rdata_q;

  // gating with resetn keeps addr_ok low while reset is held
  assign idle = (state == ST_IDLE) && resetn;

  sram_axi_arb u_arb (
    .enable   (idle),
    .inst_req (inst_req),
    .data_req (data_req),
    .inst_gnt (inst_gnt),
    .data_gnt (data_gnt)
  );

  assign inst_addr_ok = inst_gnt;
  assign data_addr_ok = data_gnt;

  assign arid   = port_data_q ? ARID_DATA : ARID_INST;
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  // a handshake is complete if it happened earlier or is happening this cycle
  assign aw_all = aw_done | awready;
  assign w_all  = w_done | wready;

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // next-state and channel control
  always_comb begin
    state_nxt    = state;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state)
      ST_IDLE: begin
        if (data_gnt)      state_nxt = data_wr ? ST_AWW : ST_AR;
        else if (inst_gnt) state_nxt = ST_AR;
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid) state_nxt = ST_DONE;
      end
      ST_AWW: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        if (aw_all && w_all) state_nxt = ST_B;
      end
      ST_B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        inst_data_ok = ~port_data_q;
        data_data_ok = port_data_q;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // capture the granted request so the AXI side sees stable values
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wr_q        <= 1'b0;
      port_data_q <= 1'b0;
    end else if (inst_gnt || data_gnt) begin
      addr_q      <= data_gnt ? data_addr : inst_addr;
      wdata_q     <= data_wdata;
      wstrb_q     <= data_wstrb;
      wr_q        <= data_gnt & data_wr;
      port_data_q <= data_gnt;
    end
  end

  // track address and data handshakes of a write independently
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == ST_AWW) begin
      if (aw_all && w_all) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        aw_done <= aw_all;
        w_done  <= w_all;
      end
    end
  end

  // read data is held per port until that port's next read returns
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else if (state == ST_R && rvalid && !wr_q) begin
      if (port_data_q) data_rdata_q <= rdata;
      else             inst_rdata_q <= rdata;
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - scoreboard bench for sram_axi_bridge
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        awready = 1'b0;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;
  logic        bready;

  typedef struct {
    bit          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int n_ok  = 0;

  int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] rd_word = '0;

  sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .awready(awready), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // AXI slave: each ready/valid answers after a programmable number of cycles
  always @(negedge clk) begin
    if (arvalid) begin arready = (ar_cnt == ar_lat); ar_cnt++; end
    else begin arready = 1'b0; ar_cnt = 0; end
    if (rready) begin
      rvalid = (r_cnt == r_lat);
      if (rvalid) rdata = rd_word;
      r_cnt++;
    end else begin rvalid = 1'b0; r_cnt = 0; end
    if (awvalid) begin awready = (aw_cnt == aw_lat); aw_cnt++; end
    else begin awready = 1'b0; aw_cnt = 0; end
    if (wvalid) begin wready = (w_cnt == w_lat); w_cnt++; end
    else begin wready = 1'b0; w_cnt = 0; end
    if (bready) begin bvalid = (b_cnt == b_lat); b_cnt++; end
    else begin bvalid = 1'b0; b_cnt = 0; end
  end

  // monitor: check handshake contents against the head entry, pop on data_ok
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (resetn) begin
      if (arvalid && arready) begin
        if (sb.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          chk("araddr", araddr, sb[0].addr);
          chk("arid", arid, sb[0].port ? 64'd1 : 64'd0);
        end
      end
      if (awvalid && awready) begin
        if (sb.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("awaddr", awaddr, sb[0].addr);
      end
      if (wvalid && wready) begin
        if (sb.size() == 0) chk("w_unexpected", 1, 0);
        else begin
          chk("wdata", wdata, sb[0].wdata);
          chk("wstrb", wstrb, sb[0].wstrb);
        end
      end
      if (inst_data_ok || data_data_ok) begin
        n_ok++;
        if (sb.size() == 0) chk("ok_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("ok_port", data_data_ok, e.port);
          chk("ok_both", inst_data_ok & data_data_ok, 0);
          if (!e.wr) chk("rdata", e.port ? data_rdata : inst_rdata, e.rdata);
        end
      end
    end
  end

  task automatic issue(input bit port, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb, input logic [31:0] exp_rd);
    exp_t e;
    @(posedge clk); #1;
    if (port) begin
      data_req = 1'b1; data_wr = wr; data_addr = addr; data_wdata = wd; data_wstrb = strb;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    @(negedge clk);
    if (port) begin
      chk("data_addr_ok", data_addr_ok, 1);
      chk("inst_addr_ok_lose", inst_addr_ok, 0);
    end else begin
      chk("inst_addr_ok", inst_addr_ok, 1);
      chk("data_addr_ok_idle", data_addr_ok, 0);
    end
    e.port = port; e.wr = wr; e.addr = addr; e.wdata = wd; e.wstrb = strb; e.rdata = exp_rd;
    sb.push_back(e);
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0;
  endtask

  task automatic wait_done(input int max, output int lat);
    bit got = 0;
    lat = 0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      lat++;
      if (inst_data_ok || data_data_ok) got = 1;
    end
    if (!got) chk("data_ok_timeout", 0, 1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_oks"}, {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    chk({tag, "_rdata"}, {inst_rdata, data_rdata}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    exp_t e;

    // reset state, with requests pending that must not be accepted
    inst_req = 1'b1; data_req = 1'b1;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    inst_req = 1'b0; data_req = 1'b0;
    #2 resetn = 1'b1;

    // minimum-latency instruction read
    rd_word = 32'h02C00000;
    issue(1'b0, 1'b0, 32'h1C000000, '0, '0, 32'h02C00000);
    @(negedge clk); chk("t1_arvalid", arvalid, 1); chk("t1_araddr", araddr, 32'h1C000000);
    chk("t1_arid", arid, 0);
    @(negedge clk); chk("t1_rready", rready, 1);
    @(negedge clk); chk("t1_ok_c3", inst_data_ok, 1); chk("t1_rdata", inst_rdata, 32'h02C00000);
    @(negedge clk); chk("t1_ok_pulse", inst_data_ok, 0); chk("t1_hold", inst_rdata, 32'h02C00000);

    // simultaneous requests: data wins, instruction waits for the next IDLE
    rd_word = 32'hA5A50001;
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h00000100;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h00000200;
    @(negedge clk);
    chk("t2_data_addr_ok", data_addr_ok, 1); chk("t2_inst_addr_ok", inst_addr_ok, 0);
    e.port = 1; e.wr = 0; e.addr = 32'h200; e.wdata = '0; e.wstrb = '0; e.rdata = 32'hA5A50001;
    sb.push_back(e);
    @(posedge clk); #1; data_req = 1'b0;
    @(negedge clk); chk("t2_arid_data", arid, 1); chk("t2_busy_c1", inst_addr_ok, 0);
    @(negedge clk); chk("t2_busy_c2", inst_addr_ok, 0);
    @(negedge clk); chk("t2_data_ok", data_data_ok, 1); chk("t2_busy_c3", inst_addr_ok, 0);
    rd_word = 32'h5A5A0002;
    @(negedge clk); chk("t2_inst_accept", inst_addr_ok, 1);
    e.port = 0; e.wr = 0; e.addr = 32'h100; e.rdata = 32'h5A5A0002;
    sb.push_back(e);
    @(posedge clk); #1; inst_req = 1'b0;
    @(negedge clk); chk("t2_arid_inst", arid, 0);
    wait_done(20, lat); chk("t2_inst_lat", lat, 2);
    chk("t2_data_hold", data_rdata, 32'hA5A50001);
    chk("t2_inst_rdata", inst_rdata, 32'h5A5A0002);

    // write with awready two cycles ahead of wready
    w_lat = 2;
    issue(1'b1, 1'b1, 32'h00000080, 32'hDEADBEEF, 4'hF, '0);
    @(negedge clk); chk("t3_c1", {awvalid, wvalid, bready}, 3'b110);
    @(negedge clk); chk("t3_c2", {awvalid, wvalid, bready}, 3'b010);
    @(negedge clk); chk("t3_c3", {awvalid, wvalid, bready}, 3'b010);
    @(negedge clk); chk("t3_c4", {awvalid, wvalid, bready}, 3'b001);
    @(negedge clk); chk("t3_ok", data_data_ok, 1);
    @(negedge clk); chk("t3_ok_pulse", data_data_ok, 0);
    w_lat = 0;

    // same-cycle aw/w completion with an all-zero strobe
    issue(1'b1, 1'b1, 32'h00000044, 32'h00001234, 4'h0, '0);
    @(negedge clk); chk("t4_c1", {awvalid, wvalid}, 2'b11); chk("t4_wstrb", wstrb, 0);
    wait_done(20, lat); chk("t4_lat", lat, 2);

    // arready held off for five cycles
    ar_lat = 5; rd_word = 32'hC0FFEE11;
    issue(1'b1, 1'b0, 32'h00003000, '0, '0, 32'hC0FFEE11);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("t5_arvalid", arvalid, 1); chk("t5_araddr", araddr, 32'h00003000);
      chk("t5_no_ok", data_data_ok, 0);
    end
    wait_done(20, lat); chk("t5_lat", lat, 3);
    ar_lat = 0;

    // reset while waiting for read data, then a clean read
    r_lat = 3; rd_word = 32'hBAD0BAD0;
    issue(1'b0, 1'b0, 32'h1C000040, '0, '0, 32'hBAD0BAD0);
    @(negedge clk);
    @(negedge clk); chk("t6_in_r", rready, 1);
    #2 resetn = 1'b0;
    #1 chk_quiet("t6_async");
    sb.delete();
    inst_req = 1'b1; data_req = 1'b1;
    repeat (2) @(negedge clk);
    chk_quiet("t6_held");
    inst_req = 1'b0; data_req = 1'b0;
    #2 resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t6_no_ok", {inst_data_ok, data_data_ok}, 0);
    end
    r_lat = 0; rd_word = 32'h13579BDF;
    issue(1'b0, 1'b0, 32'h1C000080, '0, '0, 32'h13579BDF);
    wait_done(20, lat); chk("t6_lat", lat, 3);
    chk("t6_rdata", inst_rdata, 32'h13579BDF);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("ok_count", n_ok, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
